// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display controller.
package ssd_pkg;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_DASH  = 4'hB;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [9:0][6:0] SEG_NUM = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:      return SEG_NUM[0];
            4'd1:      return SEG_NUM[1];
            4'd2:      return SEG_NUM[2];
            4'd3:      return SEG_NUM[3];
            4'd4:      return SEG_NUM[4];
            4'd5:      return SEG_NUM[5];
            4'd6:      return SEG_NUM[6];
            4'd7:      return SEG_NUM[7];
            4'd8:      return SEG_NUM[8];
            4'd9:      return SEG_NUM[9];
            DIG_MINUS: return SEG_MINUS;
            DIG_DASH:  return SEG_DASH;
            default:   return SEG_BLANK;
        endcase
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, sticky overflow.
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int unsigned NDIG = 4,
    parameter int unsigned DW   = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DW-1:0]     bin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NDIG-1:0] bcd_o,
    output logic              ovf_o
);
    localparam int unsigned CW = clog2(DW + 1);

    logic              run_q, run_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     bin_q, bin_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d, adj;
    logic              ovf_q, ovf_d;

    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < int'(NDIG); d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end

        run_d = run_q;
        cnt_d = cnt_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        if (start_i && !run_q) begin
            run_d = 1'b1;
            cnt_d = '0;
            bin_d = bin_i;
            bcd_d = '0;
            ovf_d = 1'b0;
        end else if (run_q) begin
            if (cnt_q == CW'(DW)) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                bin_d = bin_q << 1;
                bcd_d = {adj[4*NDIG-2:0], bin_q[DW-1]};
                // Bit shifted out of the top digit means the value did not fit.
                ovf_d = ovf_q | adj[4*NDIG-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            bin_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
        end
    end

    assign busy_o = run_q;
    assign done_o = run_q && (cnt_q == CW'(DW));
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q | (bcd_q[4*NDIG-1 -: 4] != 4'd0);

endmodule

// File: rtl/ssd_mux_ctrl.sv
// N-digit common-anode display controller: LOAD/BUSY handshake, BCD formatting with
// leading-zero suppression and sign placement, guarded digit scan and per-slot PWM dimming.
module ssd_mux_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned DW          = 14,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned PWM_BITS    = 3
) (
    input  logic                DCLK,
    input  logic                RST,
    input  logic                LOAD,
    input  logic [DW-1:0]       DIN,
    input  logic                NEG,
    input  logic [NDIG-1:0]     DP,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic                BUSY,
    output logic                OVF,
    output logic [NDIG-1:0]     AN,
    output logic [6:0]          SEG,
    output logic                DOT
);
    localparam int unsigned SW     = clog2(REFRESH_DIV);
    localparam int unsigned IW     = clog2(NDIG);
    localparam int unsigned SubLen = REFRESH_DIV >> PWM_BITS;

    logic              busy, done, eng_ovf;
    logic [4*NDIG-1:0] bcd;
    logic              neg_q;
    logic [NDIG-1:0]   dpl_q;

    ssd_bin2bcd #(.NDIG(NDIG), .DW(DW)) u_bin2bcd (
        .clk_i  (DCLK),
        .rst_i  (RST),
        .start_i(LOAD && !busy),
        .bin_i  (DIN),
        .busy_o (busy),
        .done_o (done),
        .bcd_o  (bcd),
        .ovf_o  (eng_ovf)
    );

    logic [NDIG-1:0][3:0] disp_q, fmt_dig;
    logic [NDIG-1:0]      dpr_q, fmt_dp;
    logic                 ovf_q;
    logic [IW-1:0]        hi;

    // Highest shown digit is the top nonzero digit or the top DP digit, never below digit 0.
    always_comb begin
        hi = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd[4*i +: 4] != 4'd0 || dpl_q[i]) hi = IW'(i);
        end
        for (int i = 0; i < int'(NDIG); i++) begin
            if (i <= int'(hi))                               fmt_dig[i] = bcd[4*i +: 4];
            else if (i == int'(hi) + 1 && neg_q && (|bcd))   fmt_dig[i] = DIG_MINUS;
            else                                             fmt_dig[i] = DIG_BLANK;
        end
        fmt_dp = dpl_q;
        if (eng_ovf) begin
            for (int i = 0; i < int'(NDIG); i++) fmt_dig[i] = DIG_DASH;
            fmt_dp = '0;
        end
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            neg_q  <= 1'b0;
            dpl_q  <= '0;
            disp_q <= {NDIG{DIG_BLANK}};
            dpr_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (LOAD && !busy) begin
                neg_q <= NEG;
                dpl_q <= DP;
            end
            if (done) begin
                disp_q <= fmt_dig;
                dpr_q  <= fmt_dp;
                ovf_q  <= eng_ovf;
            end
        end
    end

    logic [SW-1:0]   slot_q, slot_d;
    logic [IW-1:0]   dig_q, dig_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dot_q, dot_d, cdp_q, cdp_d, active;

    always_comb begin
        slot_d = slot_q + SW'(1);
        dig_d  = dig_q;
        if (slot_q == SW'(REFRESH_DIV - 1)) begin
            slot_d = '0;
            dig_d  = (dig_q == IW'(NDIG - 1)) ? '0 : dig_q + IW'(1);
        end
        seg_d = seg_q;
        cdp_d = cdp_q;
        // Display register sampled only at slot start so a commit never tears a slot.
        if (slot_d == '0) begin
            seg_d = seg_decode(disp_q[dig_d]);
            cdp_d = dpr_q[dig_d];
        end
        active = (slot_d != '0) && (32'(slot_d) < (32'(BRIGHT) + 32'd1) * SubLen);
        an_d   = active ? ~(NDIG'(1) << dig_d) : '1;
        dot_d  = ~(active && cdp_d);
    end

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            slot_q <= '0;
            dig_q  <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dot_q  <= 1'b1;
            cdp_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            dig_q  <= dig_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dot_q  <= dot_d;
            cdp_q  <= cdp_d;
        end
    end

    assign BUSY = busy;
    assign OVF  = ovf_q;
    assign AN   = an_q;
    assign SEG  = seg_q;
    assign DOT  = dot_q;

endmodule

// File: tb/tb_ssd_mux_ctrl.sv
// Directed, table-driven bench for ssd_mux_ctrl with hand-computed segment patterns.
module tb_ssd_mux_ctrl;
    localparam int unsigned NDIG = 4, DW = 14, RDIV = 16, PB = 2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000, SM = 7'b0111111, SB = 7'b1111111;

    logic          DCLK = 1'b0, RST = 1'b1, LOAD = 1'b0, NEG = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic [3:0]    DP = '0;
    logic [PB-1:0] BRIGHT = 2'd3;
    logic          BUSY, OVF, DOT;
    logic [3:0]    AN;
    logic [6:0]    SEG;

    ssd_mux_ctrl #(.NDIG(NDIG), .DW(DW), .REFRESH_DIV(RDIV), .PWM_BITS(PB)) dut (
        .DCLK(DCLK), .RST(RST), .LOAD(LOAD), .DIN(DIN), .NEG(NEG), .DP(DP), .BRIGHT(BRIGHT),
        .BUSY(BUSY), .OVF(OVF), .AN(AN), .SEG(SEG), .DOT(DOT)
    );

    always #5 DCLK = ~DCLK;

    int cyc;
    always @(posedge DCLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end
    function automatic int cur_slot(); return cyc % RDIV; endfunction
    function automatic int cur_dig(); return (cyc / RDIV) % NDIG; endfunction

    int passed = 0, total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic capture(output logic [27:0] segs, output logic [3:0] dots, output logic bad);
        bit found = 0;
        segs = '1;
        dots = '0;
        bad  = 1'b0;
        tick();
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (cur_slot() == 1 && cur_dig() == 0) found = 1;
        end
        check("frame_align", 32'(found), 32'd1);
        for (int k = 0; k < int'(RDIV * NDIG); k++) begin
            if (cur_slot() == 1) segs[cur_dig()*7 +: 7] = SEG;
            if (!DOT) begin
                dots[cur_dig()] = 1'b1;
                if (AN != ~(4'b0001 << cur_dig())) bad = 1'b1;
            end
            tick();
        end
    endtask

    task automatic load_timed(input int din, input logic neg, input logic [3:0] dp,
                              output int n);
        DIN  = DW'(din);
        NEG  = neg;
        DP   = dp;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        n = 0;
        while (BUSY && n < 40) begin
            n++;
            tick();
        end
    endtask

    typedef struct {
        int         din;
        logic       neg;
        logic [3:0] dp;
        logic       ovf;
        logic [27:0] segs;
        logic [3:0] dots;
    } vec_t;

    vec_t vt[10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [27:0] segs;
        logic [3:0]  dots;
        logic        bad;
        int          n, errs;

        vt[0] = '{123,   1'b1, 4'b0000, 1'b0, {SM, S1, S2, S3}, 4'b0000};
        vt[1] = '{5,     1'b1, 4'b0100, 1'b0, {SM, S0, S0, S5}, 4'b0100};
        vt[2] = '{0,     1'b1, 4'b0000, 1'b0, {SB, SB, SB, S0}, 4'b0000};
        vt[3] = '{1000,  1'b0, 4'b0000, 1'b1, {SM, SM, SM, SM}, 4'b0000};
        vt[4] = '{999,   1'b0, 4'b0000, 1'b0, {SB, S9, S9, S9}, 4'b0000};
        vt[5] = '{42,    1'b1, 4'b0001, 1'b0, {SB, SM, S4, S2}, 4'b0001};
        vt[6] = '{7,     1'b0, 4'b0010, 1'b0, {SB, SB, S0, S7}, 4'b0010};
        vt[7] = '{999,   1'b1, 4'b0000, 1'b0, {SM, S9, S9, S9}, 4'b0000};
        vt[8] = '{16383, 1'b1, 4'b0100, 1'b1, {SM, SM, SM, SM}, 4'b0000};
        vt[9] = '{80,    1'b1, 4'b0000, 1'b0, {SB, SM, S8, S0}, 4'b0000};

        // Reset state, then reset asserted mid-scan.
        repeat (3) tick();
        check("rst_an", 32'(AN), 32'hF);
        check("rst_seg", 32'(SEG), 32'(SB));
        check("rst_dot_busy_ovf", {DOT, BUSY, OVF}, 3'b100);
        RST = 1'b0;
        repeat (37) tick();
        RST = 1'b1;
        #1;
        check("midscan_rst_an", 32'(AN), 32'hF);
        check("midscan_rst_seg", 32'(SEG), 32'(SB));
        check("midscan_rst_dot_busy_ovf", {DOT, BUSY, OVF}, 3'b100);
        tick();
        RST = 1'b0;
        capture(segs, dots, bad);
        check("post_rst_frame", 32'(segs), 32'({SB, SB, SB, SB}));
        check("post_rst_dots", 32'(dots), 32'h0);

        for (int i = 0; i < 10; i++) begin
            load_timed(vt[i].din, vt[i].neg, vt[i].dp, n);
            check($sformatf("v%0d_busy_len", i), 32'(n), 32'(DW + 1));
            check($sformatf("v%0d_ovf", i), 32'(OVF), 32'(vt[i].ovf));
            capture(segs, dots, bad);
            check($sformatf("v%0d_segs", i), 32'(segs), 32'(vt[i].segs));
            check($sformatf("v%0d_dots", i), 32'(dots), 32'(vt[i].dots));
            check($sformatf("v%0d_dot_anode", i), 32'(bad), 32'd0);
        end

        // PWM: anode active for slot cycles 1 .. (BRIGHT+1)*4-1.
        for (int b = 0; b < 4; b++) begin
            BRIGHT = PB'(b);
            repeat (2) tick();
            errs = 0;
            for (int k = 0; k < int'(RDIV * NDIG); k++) begin
                if (AN !== ((cur_slot() != 0 && cur_slot() / 4 <= b) ?
                            ~(4'b0001 << cur_dig()) : 4'hF)) errs++;
                tick();
            end
            check($sformatf("an_pwm_b%0d", b), 32'(errs), 32'd0);
        end
        BRIGHT = 2'd3;

        // Second LOAD three cycles into a conversion is dropped.
        DIN = DW'(321); NEG = 1'b0; DP = 4'b0000; LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        n = 0;
        while (BUSY && n < 40) begin
            n++;
            if (n == 3) begin
                DIN = DW'(9999); NEG = 1'b1; LOAD = 1'b1;
            end else begin
                LOAD = 1'b0;
            end
            tick();
        end
        LOAD = 1'b0;
        check("ignore_busy_len", 32'(n), 32'(DW + 1));
        tick();
        check("ignore_not_queued", 32'(BUSY), 32'd0);
        check("ignore_ovf", 32'(OVF), 32'd0);
        capture(segs, dots, bad);
        check("ignore_segs", 32'(segs), 32'({SB, S3, S2, S1}));

        // Reset at t+5 of a conversion: nothing committed, display back to blank.
        DIN = DW'(77); NEG = 1'b1; LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        repeat (4) tick();
        check("pre_abort_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        #1;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_outputs", {AN, SEG, DOT, OVF}, {4'hF, SB, 1'b1, 1'b0});
        tick();
        RST = 1'b0;
        repeat (20) tick();
        check("abort_no_commit_busy", 32'(BUSY), 32'd0);
        capture(segs, dots, bad);
        check("abort_frame", 32'(segs), 32'({SB, SB, SB, SB}));
        check("abort_ovf", 32'(OVF), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
